// File: rtl/pin_auth_if.sv
// PIN-entry pin bundle: raw switch/button inputs in, conditioned status and
// result code out. The bench drives the master side; pin_auth is the slave.
interface pin_auth_if;
    logic       card_present;
    logic [3:0] digit_sw;
    logic       enter_btn;
    logic [1:0] card_input;
    logic [2:0] digit_count;
    logic [2:0] tries_left;
    logic       entry_active;
    logic       locked;

    modport master (
        output card_present, digit_sw, enter_btn,
        input  card_input, digit_count, tries_left, entry_active, locked
    );

    modport slave (
        input  card_present, digit_sw, enter_btn,
        output card_input, digit_count, tries_left, entry_active, locked
    );
endinterface

// File: rtl/pin_auth.sv
// PIN authentication front end: synchronises and debounces raw inputs, collects
// a PIN, compares it, and issues 10/01 codes with a retry limit and lockout.
module pin_auth #(
    parameter int                      PIN_DIGITS      = 4,
    parameter logic [4*PIN_DIGITS-1:0] PIN_VALUE       = 16'h1234,
    parameter int                      MAX_TRIES       = 3,
    parameter int                      DEBOUNCE_CYCLES = 1_000_000,
    parameter int                      RESULT_HOLD     = 4
) (
    input logic        clk,
    input logic        rst,
    pin_auth_if.slave  pin_io
);
    localparam int SRW = 4 * PIN_DIGITS;
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW  = $clog2(RESULT_HOLD + 1);

    localparam logic [2:0]     MAXF  = 3'(MAX_TRIES);
    localparam logic [2:0]     NDIG  = 3'(PIN_DIGITS);
    localparam logic [DBW-1:0] DBLAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0]  HLAST = HW'(RESULT_HOLD - 1);

    typedef enum logic [2:0] {
        S_WAIT_CARD, S_ENTRY, S_COMPARE, S_VALID_OUT,
        S_INVALID_OUT, S_SESSION, S_LOCKED
    } state_e;

    logic [1:0]      card_sync_q, btn_sync_q;
    logic [1:0][3:0] digit_sync_q;
    logic            card_s, btn_s;
    logic [3:0]      digit_s;

    assign card_s  = card_sync_q[1];
    assign btn_s   = btn_sync_q[1];
    assign digit_s = digit_sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            card_sync_q  <= '0;
            btn_sync_q   <= '0;
            digit_sync_q <= '0;
        end else begin
            card_sync_q  <= {card_sync_q[0], pin_io.card_present};
            btn_sync_q   <= {btn_sync_q[0], pin_io.enter_btn};
            digit_sync_q <= {digit_sync_q[0], pin_io.digit_sw};
        end
    end

    // Debounce: level flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles
    logic           db_level_q, db_level_d, pulse_q, pulse_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;

    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        pulse_d    = 1'b0;
        if (btn_s != db_level_q) begin
            if (db_cnt_q == DBLAST) begin
                db_level_d = btn_s;
                pulse_d    = btn_s;
            end else begin
                db_cnt_d = db_cnt_q + DBW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            pulse_q    <= 1'b0;
        end else begin
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            pulse_q    <= pulse_d;
        end
    end

    state_e         state_q, state_d;
    logic [SRW-1:0] sr_q, sr_d;
    logic [2:0]     dcnt_q, dcnt_d, fail_q, fail_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [1:0]     code_q, code_d;
    logic [2:0]     tries_q;
    logic           entry_q, locked_q, abort;

    assign abort = !card_s && (state_q == S_ENTRY || state_q == S_COMPARE ||
                               state_q == S_VALID_OUT || state_q == S_INVALID_OUT);

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        dcnt_d  = dcnt_q;
        fail_d  = fail_q;
        hold_d  = hold_q;
        if (abort) begin
            // Removal beats a same-cycle enter pulse; failures are kept
            state_d = S_WAIT_CARD;
            sr_d    = '0;
            dcnt_d  = '0;
        end else begin
            unique case (state_q)
                S_WAIT_CARD: if (card_s) begin
                    if (fail_q == MAXF) state_d = S_LOCKED;
                    else begin
                        state_d = S_ENTRY;
                        sr_d    = '0;
                        dcnt_d  = '0;
                    end
                end
                S_ENTRY: if (pulse_q) begin
                    sr_d   = SRW'({sr_q, digit_s});
                    dcnt_d = dcnt_q + 3'd1;
                    if (dcnt_d == NDIG) state_d = S_COMPARE;
                end
                S_COMPARE: begin
                    hold_d = '0;
                    if (sr_q == PIN_VALUE) begin
                        state_d = S_VALID_OUT;
                        fail_d  = '0;
                    end else begin
                        state_d = S_INVALID_OUT;
                        if (fail_q != MAXF) fail_d = fail_q + 3'd1;
                    end
                end
                S_VALID_OUT: begin
                    if (hold_q == HLAST) state_d = S_SESSION;
                    else hold_d = hold_q + HW'(1);
                end
                S_INVALID_OUT: begin
                    if (hold_q == HLAST) begin
                        if (fail_q == MAXF) state_d = S_LOCKED;
                        else begin
                            state_d = S_ENTRY;
                            sr_d    = '0;
                            dcnt_d  = '0;
                        end
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                S_SESSION, S_LOCKED: if (!card_s) state_d = S_WAIT_CARD;
                default: state_d = S_WAIT_CARD;
            endcase
        end

        code_d = 2'b00;
        if (state_d == S_VALID_OUT)   code_d = 2'b10;
        if (state_d == S_INVALID_OUT) code_d = 2'b01;
    end

    // Outputs are registered from next-state so they align with the state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_WAIT_CARD;
            sr_q     <= '0;
            dcnt_q   <= '0;
            fail_q   <= '0;
            hold_q   <= '0;
            code_q   <= 2'b00;
            tries_q  <= MAXF;
            entry_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            dcnt_q   <= dcnt_d;
            fail_q   <= fail_d;
            hold_q   <= hold_d;
            code_q   <= code_d;
            tries_q  <= MAXF - fail_d;
            entry_q  <= (state_d == S_ENTRY);
            locked_q <= (state_d == S_LOCKED);
        end
    end

    assign pin_io.card_input   = code_q;
    assign pin_io.digit_count  = dcnt_q;
    assign pin_io.tries_left   = tries_q;
    assign pin_io.entry_active = entry_q;
    assign pin_io.locked       = locked_q;
endmodule

// File: tb/tb_pin_auth.sv
// Directed bench for pin_auth: expected result codes are queued as PINs are
// entered and popped by a monitor when card_input leaves 00.
module tb_pin_auth;
    localparam int RESULT_HOLD = 4;

    logic clk, rst;
    pin_auth_if dif();

    pin_auth #(
        .PIN_DIGITS(4), .PIN_VALUE(16'h1234), .MAX_TRIES(3),
        .DEBOUNCE_CYCLES(4), .RESULT_HOLD(RESULT_HOLD)
    ) dut (
        .clk(clk), .rst(rst), .pin_io(dif)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         hold_len = 0;
    logic [1:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Result-code scoreboard and hold-length check
    always @(posedge clk) begin
        #1;
        if (rst) hold_len = 0;
        else if (dif.card_input != 2'b00) begin
            if (hold_len == 0) begin
                if (exp_q.size() == 0) chk("code_unexpected", int'(dif.card_input), 0);
                else chk("code", int'(dif.card_input), int'(exp_q.pop_front()));
            end
            hold_len++;
        end else if (hold_len != 0) begin
            chk("hold_len", hold_len, RESULT_HOLD);
            hold_len = 0;
        end
    end

    // Clean press: count must be unchanged after 6 edges and updated after 7
    task automatic press_digit(input logic [3:0] d, input int cnt);
        dif.digit_sw  = d;
        dif.enter_btn = 1'b1;
        tick(6);
        chk("dcnt_pre", int'(dif.digit_count), cnt - 1);
        tick(1);
        chk("dcnt", int'(dif.digit_count), cnt);
        tick(1);
        dif.enter_btn = 1'b0;
        tick(8);
    endtask

    task automatic enter_pin(input logic [15:0] pin, input logic [1:0] code);
        exp_q.push_back(code);
        for (int k = 0; k < 4; k++) press_digit(pin[15-4*k -: 4], k + 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_code"},   int'(dif.card_input), 0);
        chk({tag, "_dcnt"},   int'(dif.digit_count), 0);
        chk({tag, "_tries"},  int'(dif.tries_left), 3);
        chk({tag, "_entry"},  int'(dif.entry_active), 0);
        chk({tag, "_locked"}, int'(dif.locked), 0);
    endtask

    initial begin
        rst = 1'b1;
        dif.card_present = 1'b0;
        dif.digit_sw     = 4'h0;
        dif.enter_btn    = 1'b0;
        tick(2);
        chk_reset_vals("reset");
        rst = 1'b0;

        // Correct PIN, 3-cycle insert latency
        dif.card_present = 1'b1;
        tick(2);
        chk("insert_early", int'(dif.entry_active), 0);
        tick(1);
        chk("insert_entry", int'(dif.entry_active), 1);
        enter_pin(16'h1234, 2'b10);
        chk("ok_code_idle", int'(dif.card_input), 0);
        chk("ok_entry", int'(dif.entry_active), 0);
        chk("ok_tries", int'(dif.tries_left), 3);
        dif.card_present = 1'b0;
        tick(4);
        chk("remove_entry", int'(dif.entry_active), 0);
        chk("remove_locked", int'(dif.locked), 0);

        // One wrong attempt, then correct
        dif.card_present = 1'b1;
        tick(3);
        enter_pin(16'h1235, 2'b01);
        chk("bad_tries", int'(dif.tries_left), 2);
        chk("bad_dcnt", int'(dif.digit_count), 0);
        chk("bad_entry", int'(dif.entry_active), 1);
        enter_pin(16'h1234, 2'b10);
        chk("retry_tries", int'(dif.tries_left), 3);
        dif.card_present = 1'b0;
        tick(4);

        // Lockout after three failures
        dif.card_present = 1'b1;
        tick(3);
        for (int a = 0; a < 3; a++) begin
            enter_pin(16'h1111, 2'b01);
            chk("lock_tries", int'(dif.tries_left), 2 - a);
        end
        chk("lock_locked", int'(dif.locked), 1);
        chk("lock_entry", int'(dif.entry_active), 0);
        dif.card_present = 1'b0;
        tick(4);
        chk("lock_removed", int'(dif.locked), 0);
        chk("lock_kept_tries", int'(dif.tries_left), 0);
        dif.card_present = 1'b1;
        tick(4);
        chk("lock_reinsert", int'(dif.locked), 1);
        chk("lock_reinsert_entry", int'(dif.entry_active), 0);
        rst = 1'b1;
        tick(1);
        chk("lock_rst_tries", int'(dif.tries_left), 3);
        chk("lock_rst_locked", int'(dif.locked), 0);
        rst = 1'b0;

        // Bouncy button yields one digit, then removal beats a same-cycle pulse
        tick(3);
        chk("reentry", int'(dif.entry_active), 1);
        dif.digit_sw = 4'h7;
        for (int t = 0; t < 10; t++) begin
            dif.enter_btn = ~dif.enter_btn;
            tick(2);
        end
        dif.enter_btn = 1'b1;
        tick(10);
        chk("bounce_dcnt", int'(dif.digit_count), 1);
        dif.enter_btn = 1'b0;
        tick(8);
        press_digit(4'h8, 2);
        dif.digit_sw  = 4'h5;
        dif.enter_btn = 1'b1;
        tick(4);
        dif.card_present = 1'b0;
        tick(2);
        chk("abort_pre_dcnt", int'(dif.digit_count), 2);
        chk("abort_pre_entry", int'(dif.entry_active), 1);
        tick(1);
        chk("abort_dcnt", int'(dif.digit_count), 0);
        chk("abort_entry", int'(dif.entry_active), 0);
        chk("abort_code", int'(dif.card_input), 0);
        chk("abort_tries", int'(dif.tries_left), 3);
        dif.enter_btn = 1'b0;
        tick(8);

        // Reset in the second cycle of an invalid hold
        dif.card_present = 1'b1;
        tick(3);
        press_digit(4'h9, 1);
        press_digit(4'h9, 2);
        press_digit(4'h9, 3);
        exp_q.push_back(2'b01);
        dif.digit_sw  = 4'h9;
        dif.enter_btn = 1'b1;
        tick(7);
        chk("hold_dcnt", int'(dif.digit_count), 4);
        tick(2);
        chk("hold_second", int'(dif.card_input), 1);
        chk("hold_tries", int'(dif.tries_left), 2);
        rst = 1'b1;
        dif.enter_btn = 1'b0;
        tick(1);
        chk_reset_vals("midrst");
        rst = 1'b0;
        dif.card_present = 1'b0;
        tick(6);
        chk("sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pin_auth.md
# pin_auth

PIN-entry authentication stage sitting directly upstream of the ATM transaction FSM. It conditions the raw card-present switch, digit switches and enter button, collects a fixed-length PIN, compares it against a parameterised PIN, and drives the 2-bit `card_input` code the transaction FSM consumes. The code values are 00 = none, 10 = valid, 01 = invalid. It also enforces a retry limit with lockout.

## Interface
- `PIN_DIGITS`, 4: number of digits per PIN (1–7).
- `PIN_VALUE`, 16'h1234: expected PIN, 4 bits per digit, first-entered digit in the MS nibble; width 4*PIN_DIGITS.
- `MAX_TRIES`, 3: consecutive failures before lockout (1–7).
- `DEBOUNCE_CYCLES`, 1_000_000: stable-cycle count required to accept an `enter_btn` level change.
- `RESULT_HOLD`, 4: cycles a valid/invalid code is held on `card_input` (≥2).
- `clk` input 1: single system clock.
- `rst` input 1: synchronous, active-high reset.
- `card_present` input 1: raw card switch, asynchronous.
- `digit_sw` input 4: raw digit switches, asynchronous.
- `enter_btn` input 1: raw push button, asynchronous, bouncy.
- `card_input` output 2: code to the transaction FSM (00/10/01).
- `digit_count` output 3: digits captured in the current attempt.
- `tries_left` output 3: MAX_TRIES minus failures so far.
- `entry_active` output 1: high while accepting digits.
- `locked` output 1: high while locked out.

## Operation
- Synchronisers: `card_present`, `digit_sw` and `enter_btn` each pass through a 2-flop synchroniser.
- Debounce: a counter tracks the synchronised `enter_btn` level against the debounced level.
  - The counter resets whenever the two levels agree.
  - When the levels disagree for DEBOUNCE_CYCLES consecutive cycles, the debounced level flips.
  - A debounced 0→1 transition produces a single-cycle `enter_pulse`.
- FSM states and transitions:
  - WAIT_CARD: if card present and failures == MAX_TRIES → LOCKED. Else if card present → ENTRY, clearing the digit shift register and `digit_count`.
  - ENTRY: `entry_active`=1.
    - On `enter_pulse`, shift synchronised `digit_sw` into the LS nibble and increment `digit_count`.
    - When `digit_count` reaches PIN_DIGITS → COMPARE.
  - COMPARE: one cycle, compares the shift register with PIN_VALUE.
    - Match → VALID_OUT; clear the failure counter.
    - Mismatch → INVALID_OUT; increment the failure counter, saturating at MAX_TRIES.
  - VALID_OUT: `card_input`=10 for RESULT_HOLD cycles → SESSION.
  - INVALID_OUT: `card_input`=01 for RESULT_HOLD cycles.
    - If failures == MAX_TRIES → LOCKED.
    - Else → ENTRY, with digits cleared.
  - SESSION: `card_input`=00; waits for card removal → WAIT_CARD.
  - LOCKED: `locked`=1, `card_input`=00; card removal → WAIT_CARD. The failure counter is kept, so the next insertion returns to LOCKED.
- Card removal: removal of the synchronised card in ENTRY, COMPARE or either OUT state aborts to WAIT_CARD.
  - Digits and `digit_count` are cleared.
  - The failure counter is kept.
  - `card_input` goes to 00 on the next cycle.
- Ignored inputs: `enter_pulse` is ignored outside ENTRY. Digit values A–F are accepted and compared as-is.
- Failure counter: cleared only by `rst` or a successful compare.
- `tries_left`: equals MAX_TRIES − failures.

## Timing
- Reset values: `card_input`=00, `digit_count`=0, `tries_left`=MAX_TRIES, `entry_active`=0, `locked`=0. State resets to WAIT_CARD, debounced level to 0, debounce counter to 0.
- All outputs are registered.
- Raw `card_present` rise → ENTRY (`entry_active`=1) in 3 cycles: 2 sync + 1 state.
- Clean raw `enter_btn` rise → `enter_pulse` after 2 + DEBOUNCE_CYCLES cycles; `digit_count` updates 1 cycle later.
- Bounce: a bounce shorter than DEBOUNCE_CYCLES produces no pulse. Holding the button produces exactly one pulse; release must also debounce before the next press registers.
- Last-digit capture → COMPARE next cycle → `card_input` valid/invalid the following cycle, held exactly RESULT_HOLD cycles, then 00.
- Simultaneous events: removal and `enter_pulse` in the same cycle → removal wins and the digit is not captured.
- `rst` mid-operation returns all state and outputs to reset values on the next edge, including the failure counter.

## Test plan
- Correct PIN (DEBOUNCE_CYCLES=4, PIN 1,2,3,4):
  - Insert card, enter the four digits → `digit_count` 1..4.
  - `card_input`=10 for exactly 4 cycles, then 00; `tries_left`=3.
  - Remove card → WAIT_CARD.
- One wrong attempt then correct:
  - Enter 1,2,3,5 → `card_input`=01 for 4 cycles; `tries_left`=2; back in ENTRY with `digit_count`=0.
  - Enter 1,2,3,4 → `card_input`=10; `tries_left`=3.
- Lockout:
  - Three wrong PINs → third 01 hold, then `locked`=1, `tries_left`=0.
  - Remove and reinsert → `locked`=1 again, no 10/01 issued.
  - `rst` → `tries_left`=3, `locked`=0.
- Debounce:
  - Toggle `enter_btn` every 2 cycles for 20 cycles, then hold high 10 cycles → exactly one digit captured.
- Removal abort:
  - After 2 digits, drop `card_present` in the same cycle as an `enter_pulse` → `digit_count`=0, `entry_active`=0, no result code, `tries_left` unchanged.
- Reset mid-hold:
  - Assert `rst` during the second cycle of a 01 hold → `card_input`=00 next cycle; all outputs at reset values.
